// File: rtl/instr_assembler_if.sv
// Handshake bundle for instr_assembler: the field-tuple input side, the
// instruction-word output side, and the occupancy/error status.
// master = producer/consumer environment, slave = the assembler itself.
interface instr_assembler_if #(
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             in_valid;
    logic             in_ready;
    logic [1:0]       fmt;
    logic [5:0]       op;
    logic [4:0]       rs;
    logic [4:0]       rt;
    logic [4:0]       rd;
    logic [4:0]       shamt;
    logic [5:0]       func;
    logic [15:0]      immediate;
    logic [25:0]      instrIndex;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_instr;
    logic [31:0]      out_addr;
    logic [CNT_W-1:0] count;
    logic             err;

    modport master (
        output in_valid, fmt, op, rs, rt, rd, shamt, func, immediate, instrIndex,
        output out_ready,
        input  in_ready, out_valid, out_instr, out_addr, count, err
    );

    modport slave (
        input  in_valid, fmt, op, rs, rt, rd, shamt, func, immediate, instrIndex,
        input  out_ready,
        output in_ready, out_valid, out_instr, out_addr, count, err
    );
endinterface

// File: rtl/instr_assembler.sv
// instr_assembler: packs R/I/J field tuples into 32-bit MIPS words, tags each
// with a sequential byte address and buffers {word, address} in a DEPTH-entry
// FIFO with valid/ready on both sides. Words only reach out_* from storage,
// so a word pushed in one cycle appears at the head the next cycle.
// Optional build macro ASM_CHECK_EN: also rejects malformed R/I/J tuples
// (R with op!=0, I/J with op==0, R with both shamt and func[5:2] nonzero).
// Without it only fmt=3 is rejected.
module instr_assembler #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
    input logic             clk,
    input logic             reset,
    input logic             flush,
    instr_assembler_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [31:0]      instr_mem [DEPTH];
    logic [31:0]      addr_mem  [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic [31:0]      next_addr;
    logic             err_q;

    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             reject;
    logic             enq;
    logic [31:0]      packed_word;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign push  = bus.in_valid && !full;
    assign pop   = bus.out_ready && !empty;
    assign enq   = push && !reject;

    // Assemble the instruction word from the fields selected by fmt.
    always_comb begin
        packed_word = 32'd0;
        case (bus.fmt)
            2'd0:    packed_word = {bus.op, bus.rs, bus.rt, bus.rd, bus.shamt, bus.func};
            2'd1:    packed_word = {bus.op, bus.rs, bus.rt, bus.immediate};
            2'd2:    packed_word = {bus.op, bus.instrIndex};
            default: packed_word = 32'd0;
        endcase
    end

    // Decide whether the presented tuple is consumed without being enqueued.
    always_comb begin
        reject = (bus.fmt == 2'd3);
`ifdef ASM_CHECK_EN
        if (bus.fmt == 2'd0 && bus.op != 6'd0)
            reject = 1'b1;
        if ((bus.fmt == 2'd1 || bus.fmt == 2'd2) && bus.op == 6'd0)
            reject = 1'b1;
        if (bus.fmt == 2'd0 && bus.shamt != 5'd0 && bus.func[5:2] != 4'd0)
            reject = 1'b1;
`endif
    end

    // FIFO control: pointers, occupancy, address counter and the err pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            next_addr <= BASE_ADDR;
            err_q     <= 1'b0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            next_addr <= BASE_ADDR;
            err_q     <= 1'b0;
        end else begin
            err_q <= push && reject;
            if (enq) begin
                wr_ptr    <= wr_ptr + PTR_W'(1);
                next_addr <= next_addr + 32'd4;
            end
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({enq, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Word/address storage; contents are only meaningful while counted.
    always_ff @(posedge clk) begin
        if (enq && !flush) begin
            instr_mem[wr_ptr] <= packed_word;
            addr_mem[wr_ptr]  <= next_addr;
        end
    end

    assign bus.in_ready  = !full;
    assign bus.out_valid = !empty;
    assign bus.out_instr = empty ? 32'd0 : instr_mem[rd_ptr];
    assign bus.out_addr  = empty ? 32'd0 : addr_mem[rd_ptr];
    assign bus.count     = count_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_instr_assembler.sv
// Bench for instr_assembler: directed scenarios plus randomized traffic.
// A predictor turns every accepted tuple into an expected {word, address}
// using the packing rules written as field-weight arithmetic; a separate
// monitor pops and compares whenever the DUT hands a word over.
module tb_instr_assembler;
    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0000_3000;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic flush = 1'b0;

    instr_assembler_if #(.DEPTH(DEPTH)) bus ();

    instr_assembler #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] exp_q [$];
    logic [31:0] model_addr   = BASE;
    logic        exp_err_next = 1'b0;
    logic        exp_err_cur  = 1'b0;
    logic [63:0] mon_e;

    // Word value from field weights: op at 2^26, rs at 2^21, rt at 2^16, ...
    function automatic logic [31:0] ref_pack(input logic [1:0] f, input logic [5:0] o,
                                             input logic [4:0] s, input logic [4:0] t,
                                             input logic [4:0] d, input logic [4:0] sh,
                                             input logic [5:0] fn, input logic [15:0] im,
                                             input logic [25:0] ix);
        logic [31:0] w;
        case (f)
            2'd0: w = 32'(o) * 32'h0400_0000 + 32'(s) * 32'h0020_0000 + 32'(t) * 32'h0001_0000
                    + 32'(d) * 32'h0000_0800 + 32'(sh) * 32'h0000_0040 + 32'(fn);
            2'd1: w = 32'(o) * 32'h0400_0000 + 32'(s) * 32'h0020_0000 + 32'(t) * 32'h0001_0000
                    + 32'(im);
            2'd2: w = 32'(o) * 32'h0400_0000 + 32'(ix);
            default: w = 32'd0;
        endcase
        return w;
    endfunction

    function automatic bit ref_reject(input logic [1:0] f, input logic [5:0] o,
                                      input logic [4:0] sh, input logic [5:0] fn);
        bit r;
        r = (f == 2'd3);
`ifdef ASM_CHECK_EN
        if (f == 2'd0 && o != 0) r = 1'b1;
        if ((f == 2'd1 || f == 2'd2) && o == 0) r = 1'b1;
        if (f == 2'd0 && sh != 0 && fn >= 6'd4) r = 1'b1;
`else
        if (o == 6'd63 && sh == 5'd31 && fn == 6'd63) r = r;
`endif
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Predictor: record what each completed handshake should produce.
    always @(negedge clk) begin
        if (!reset || flush) begin
            exp_q.delete();
            model_addr   = BASE;
            exp_err_next = 1'b0;
        end else begin
            exp_err_next = 1'b0;
            if (bus.in_valid && bus.in_ready) begin
                if (ref_reject(bus.fmt, bus.op, bus.shamt, bus.func)) begin
                    exp_err_next = 1'b1;
                end else begin
                    exp_q.push_back({ref_pack(bus.fmt, bus.op, bus.rs, bus.rt, bus.rd, bus.shamt,
                                              bus.func, bus.immediate, bus.instrIndex), model_addr});
                    model_addr = model_addr + 32'd4;
                end
            end
        end
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) exp_err_cur = 1'b0;
        else        exp_err_cur = exp_err_next;
    end

    // Monitor: compare every handed-over word and the err pulse.
    always @(negedge clk) begin
        if (reset) begin
            check("err_pulse", 32'(bus.err), 32'(exp_err_cur));
            if (!bus.out_valid) begin
                check("empty_instr", bus.out_instr, 32'd0);
                check("empty_addr", bus.out_addr, 32'd0);
            end else if (!flush && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_word: got 0x%08h @0x%08h, expected none",
                             bus.out_instr, bus.out_addr);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("pop_instr", bus.out_instr, mon_e[63:32]);
                    check("pop_addr", bus.out_addr, mon_e[31:0]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_tuple(input logic [1:0] f, input logic [5:0] o, input logic [4:0] s,
                               input logic [4:0] t, input logic [4:0] d, input logic [4:0] sh,
                               input logic [5:0] fn, input logic [15:0] im, input logic [25:0] ix);
        bus.in_valid   = 1'b1;
        bus.fmt        = f;
        bus.op         = o;
        bus.rs         = s;
        bus.rt         = t;
        bus.rd         = d;
        bus.shamt      = sh;
        bus.func       = fn;
        bus.immediate  = im;
        bus.instrIndex = ix;
    endtask

    // wild=0: a tuple accepted in every build; wild=1: any field values.
    task automatic drive_rand(input bit wild);
        logic [1:0] f;
        logic [5:0] o;
        logic [4:0] sh;
        logic [5:0] fn;
        if (wild) begin
            f  = 2'($urandom_range(0, 3));
            o  = 6'($urandom);
            sh = 5'($urandom);
            fn = 6'($urandom);
        end else begin
            f  = 2'($urandom_range(0, 2));
            o  = (f == 2'd0) ? 6'd0 : 6'($urandom_range(1, 63));
            sh = 5'($urandom);
            fn = (sh != 0) ? 6'($urandom_range(0, 3)) : 6'($urandom);
        end
        drive_tuple(f, o, 5'($urandom), 5'($urandom), 5'($urandom), sh, fn,
                    16'($urandom), 26'($urandom));
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        drive_tuple(2'd0, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0);
        bus.in_valid  = 1'b0;
        repeat (3) step();

        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_instr", bus.out_instr, 32'd0);
        check("rst_out_addr", bus.out_addr, 32'd0);
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        reset = 1'b1;
        step();

        // R, I, J words with one-cycle latency and sequential addresses
        drive_tuple(2'd0, 6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21, 16'd0, 26'd0);
        step();
        bus.in_valid = 1'b0;
        check("r_valid", 32'(bus.out_valid), 32'd1);
        check("r_instr", bus.out_instr, 32'h0022_1821);
        check("r_addr", bus.out_addr, 32'h0000_3000);
        drive_tuple(2'd1, 6'h0d, 5'd0, 5'd1, 5'd0, 5'd0, 6'd0, 16'h1234, 26'd0);
        step();
        drive_tuple(2'd2, 6'h03, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h0C03);
        step();
        bus.in_valid = 1'b0;
        check("three_count", 32'(bus.count), 32'd3);
        bus.out_ready = 1'b1;
        step();
        check("i_instr", bus.out_instr, 32'h3401_1234);
        check("i_addr", bus.out_addr, 32'h0000_3004);
        step();
        check("j_instr", bus.out_instr, 32'h0C00_0C03);
        check("j_addr", bus.out_addr, 32'h0000_3008);
        step();
        bus.out_ready = 1'b0;
        check("drained_valid", 32'(bus.out_valid), 32'd0);
        check("drained_count", 32'(bus.count), 32'd0);

        // fill to full, fifth tuple held until a pop frees a slot
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_rand(1'b0);
            if (i < 4) step();
        end
        check("full_count", 32'(bus.count), 32'd4);
        check("full_in_ready", 32'(bus.in_ready), 32'd0);
        step();
        check("held_count", 32'(bus.count), 32'd4);
        bus.out_ready = 1'b1;
        step();
        check("reopen_in_ready", 32'(bus.in_ready), 32'd1);
        check("reopen_count", 32'(bus.count), 32'd3);
        bus.out_ready = 1'b0;
        step();
        bus.in_valid = 1'b0;
        check("refill_count", 32'(bus.count), 32'd4);
        bus.out_ready = 1'b1;
        repeat (3) step();
        check("fifth_addr", bus.out_addr, 32'h0000_3010);
        check("fifth_count", 32'(bus.count), 32'd1);
        step();
        bus.out_ready = 1'b0;

        // rejected tuple: err pulse, nothing queued, address not consumed
        drive_rand(1'b0);
        bus.fmt = 2'd3;
        step();
        bus.in_valid = 1'b0;
        check("rej_err", 32'(bus.err), 32'd1);
        check("rej_count", 32'(bus.count), 32'd0);
        step();
        check("rej_err_clear", 32'(bus.err), 32'd0);
        drive_rand(1'b0);
        step();
        bus.in_valid = 1'b0;
        check("post_rej_addr", bus.out_addr, 32'h0000_3014);
`ifdef ASM_CHECK_EN
        drive_tuple(2'd0, 6'h0d, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21, 16'd0, 26'd0);
        step();
        bus.in_valid = 1'b0;
        check("chk_r_op_err", 32'(bus.err), 32'd1);
        check("chk_r_op_count", 32'(bus.count), 32'd1);
`endif
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;

        // flush with three queued, push and pop in the flush cycle discarded
        for (int i = 0; i < 3; i++) begin
            drive_rand(1'b0);
            step();
        end
        drive_rand(1'b0);
        bus.out_ready = 1'b1;
        flush = 1'b1;
        step();
        flush = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check("flush_count", 32'(bus.count), 32'd0);
        check("flush_valid", 32'(bus.out_valid), 32'd0);
        drive_rand(1'b0);
        step();
        bus.in_valid = 1'b0;
        check("flush_next_addr", bus.out_addr, 32'h0000_3000);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;

        // asynchronous reset in the middle of a stream
        for (int i = 0; i < 2; i++) begin
            drive_rand(1'b0);
            step();
        end
        bus.in_valid = 1'b0;
        reset = 1'b0;
        #1;
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_count", 32'(bus.count), 32'd0);
        check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        step();
        reset = 1'b1;
        drive_rand(1'b0);
        step();
        bus.in_valid = 1'b0;
        check("mid_rst_next_addr", bus.out_addr, 32'h0000_3000);
        bus.out_ready = 1'b1;
        step();

        // full-rate streaming: push and pop every cycle
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int i = 0; i < 16; i++) begin
            drive_rand(1'b0);
            step();
            check("stream_count", 32'(bus.count), 32'd1);
            check("stream_addr", bus.out_addr, BASE + 32'(i) * 32'd4);
        end
        bus.in_valid = 1'b0;
        step();
        bus.out_ready = 1'b0;

        // randomized traffic with occasional bad tuples and flushes
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) != 0) drive_rand(1'b1);
            else                           bus.in_valid = 1'b0;
            bus.out_ready = ($urandom_range(0, 2) != 0);
            flush         = ($urandom_range(0, 39) == 0);
            step();
        end
        bus.in_valid  = 1'b0;
        flush         = 1'b0;
        bus.out_ready = 1'b1;
        begin
            int budget;
            budget = 20;
            while ((exp_q.size() != 0 || bus.out_valid) && budget > 0) begin
                step();
                budget--;
            end
            check("final_drain", 32'(exp_q.size()), 32'd0);
            check("final_count", 32'(bus.count), 32'd0);
        end
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
